// File: rtl/argmin_result_sink.sv
// Root-side sink of the census argmin tree: tracks valid slots, tags
// confidence and end-of-line, buffers results and back-pressures the tree.
//
// Ports:
//   clk, rst (async, active low)
//   in_valid   : leaves entering the tree this cycle are a real pixel
//   tree_en    : shared enable of every argmin stage (upstream ready)
//   min_val    : root minimum cost
//   min_addr   : root disparity
//   thresh     : confidence threshold
//   out_valid, out_ready : head handshake
//   out_disp, out_cost, out_conf, out_last : head entry fields
//   level      : FIFO occupancy
module argmin_result_sink #(
  parameter int WIDTH      = 6,
  parameter int ADDR_WIDTH = 6,
  parameter int STAGES     = 6,
  parameter int DEPTH      = 8,
  parameter int LINE_W     = 320
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    tree_en,
  input  logic [WIDTH-1:0]        min_val,
  input  logic [ADDR_WIDTH-1:0]   min_addr,
  input  logic [WIDTH-1:0]        thresh,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ADDR_WIDTH-1:0]   out_disp,
  output logic [WIDTH-1:0]        out_cost,
  output logic                    out_conf,
  output logic                    out_last,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = (LINE_W > 1) ? $clog2(LINE_W) : 1;
  localparam logic [PW:0]   FULL = (PW+1)'(DEPTH);
  localparam logic [CW-1:0] LAST = CW'(LINE_W - 1);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] disp;
    logic [WIDTH-1:0]      cost;
    logic                  conf;
    logic                  last;
  } ent_t;

  logic [STAGES-1:0] vld;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     line_cnt;
  ent_t              mem [DEPTH];
  ent_t              wr_ent;
  ent_t              head;
  logic              push;
  logic              pop;

  assign out_valid = (level != '0);
  assign pop       = out_valid & out_ready;
  // A pop frees the slot a same-cycle push needs, so full+pop still runs.
  assign tree_en   = (level < FULL) | pop;
  assign push      = tree_en & vld[STAGES-1];

  // Valid bits move in lockstep with the tree registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld <= '0;
    end else if (tree_en) begin
      vld[0] <= in_valid;
      for (int i = 1; i < STAGES; i++) begin
        vld[i] <= vld[i-1];
      end
    end
  end

  always_comb begin
    wr_ent      = '0;
    wr_ent.disp = min_addr;
    wr_ent.cost = min_val;
    wr_ent.conf = (min_val <= thresh);
    wr_ent.last = (line_cnt == LAST);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_ent;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      line_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + PW'(1);
        line_cnt <= (line_cnt == LAST) ? '0 : line_cnt + CW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   level <= level + (PW+1)'(1);
        2'b01:   level <= level - (PW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  always_comb begin
    head     = mem[rd_ptr];
    out_disp = '0;
    out_cost = '0;
    out_conf = 1'b0;
    out_last = 1'b0;
    if (out_valid) begin
      out_disp = head.disp;
      out_cost = head.cost;
      out_conf = head.conf;
      out_last = head.last;
    end
  end

endmodule

// File: tb/tb_argmin_result_sink.sv
// Bench for argmin_result_sink: emulates the argmin tree latency and
// checks every popped result against an ordered expectation queue.
module tb_argmin_result_sink;

  localparam int WIDTH  = 6;
  localparam int AW     = 6;
  localparam int STAGES = 6;
  localparam int DEPTH  = 8;
  localparam int LINE_W = 320;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             tree_en;
  logic [WIDTH-1:0] min_val = '0;
  logic [AW-1:0]    min_addr = '0;
  logic [WIDTH-1:0] thresh = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [AW-1:0]    out_disp;
  logic [WIDTH-1:0] out_cost;
  logic             out_conf;
  logic             out_last;
  logic [3:0]       level;

  always #5 clk = ~clk;

  argmin_result_sink #(
    .WIDTH(WIDTH), .ADDR_WIDTH(AW), .STAGES(STAGES),
    .DEPTH(DEPTH), .LINE_W(LINE_W)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .tree_en(tree_en),
    .min_val(min_val), .min_addr(min_addr), .thresh(thresh),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_disp(out_disp), .out_cost(out_cost),
    .out_conf(out_conf), .out_last(out_last), .level(level)
  );

  typedef struct {
    int disp;
    int cost;
    int conf;
    int last;
  } exp_t;

  typedef struct {
    int val;
    int addr;
    int th;
    int conf;
  } vec_t;

  exp_t exp_q[$];
  int   last_hits[$];
  int   pv [STAGES];
  int   pa [STAGES];
  int   push_cnt = 0;
  int   pop_cnt  = 0;
  int   n_cmp    = 0;
  int   n_fail   = 0;
  bit   last_en  = 1'b1;
  int   leaf_v   = 0;
  int   leaf_val = 0;
  int   leaf_addr = 0;
  bit   obs_en, obs_pop, obs_valid;
  int   obs_disp, obs_cost, obs_conf;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic flush();
    exp_q.delete();
    push_cnt  = 0;
    last_en   = 1'b1;
    leaf_v    = 0;
    in_valid  = 1'b0;
    for (int i = 0; i < STAGES; i++) begin
      pv[i] = 0;
      pa[i] = 0;
    end
    min_val  = '0;
    min_addr = '0;
  endtask

  // One clock: sample at negedge, then advance the emulated tree.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    obs_en    = tree_en;
    obs_valid = out_valid;
    obs_pop   = out_valid & out_ready;
    obs_disp  = out_disp;
    obs_cost  = out_cost;
    obs_conf  = out_conf;
    if (!out_valid)
      chk("idle_zero", {out_disp, out_cost, out_conf, out_last}, 0);
    if (obs_pop) begin
      pop_cnt++;
      if (out_last) last_hits.push_back(pop_cnt);
      if (exp_q.size() == 0) begin
        chk("unexpected_pop", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("head_disp", out_disp, e.disp);
        chk("head_cost", out_cost, e.cost);
        chk("head_conf", out_conf, e.conf);
        chk("head_last", out_last, e.last);
      end
    end
    @(posedge clk);
    #1;
    last_en = obs_en;
    if (obs_en) begin
      for (int i = STAGES - 1; i > 0; i--) begin
        pv[i] = pv[i-1];
        pa[i] = pa[i-1];
      end
      pv[0] = leaf_val;
      pa[0] = leaf_addr;
      if (leaf_v != 0) begin
        e.disp = leaf_addr;
        e.cost = leaf_val;
        e.conf = (leaf_val <= int'(thresh)) ? 1 : 0;
        e.last = ((push_cnt % LINE_W) == LINE_W - 1) ? 1 : 0;
        exp_q.push_back(e);
        push_cnt++;
      end
    end
    min_val  = WIDTH'(pv[STAGES-1]);
    min_addr = AW'(pa[STAGES-1]);
  endtask

  // New leaves are only offered after the tree took the previous ones.
  task automatic drive(input int v, input int val, input int addr,
                       input bit rdy);
    out_ready = rdy;
    if (last_en) begin
      leaf_v    = v;
      leaf_val  = val;
      leaf_addr = addr;
      in_valid  = (v != 0);
    end
    tick();
  endtask

  task automatic rnd(input int v, input bit rdy);
    drive(v, $urandom_range(0, 63), $urandom_range(0, 63), rdy);
  endtask

  task automatic reset_all();
    rst = 1'b0;
    flush();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic drain(input int max);
    for (int i = 0; i < max; i++) begin
      if (exp_q.size() == 0 && level == 0 && !in_valid) break;
      rnd(0, 1'b1);
    end
    chk("drain_queue_empty", exp_q.size(), 0);
    chk("drain_level_zero", level, 0);
  endtask

  vec_t vecs [6];

  initial begin
    vecs[0] = '{val: 8,  addr: 3,  th: 8,  conf: 1};
    vecs[1] = '{val: 9,  addr: 4,  th: 8,  conf: 0};
    vecs[2] = '{val: 0,  addr: 1,  th: 0,  conf: 1};
    vecs[3] = '{val: 1,  addr: 2,  th: 0,  conf: 0};
    vecs[4] = '{val: 63, addr: 63, th: 63, conf: 1};
    vecs[5] = '{val: 62, addr: 5,  th: 61, conf: 0};
    flush();

    // Reset state
    #12;
    chk("rst_level", level, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_tree_en", tree_en, 1);
    chk("rst_outputs", {out_disp, out_cost, out_conf, out_last}, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Latency: one pixel, result visible exactly in cycle STAGES+1
    thresh = 8;
    for (int k = 0; k < 10; k++) begin
      if (k == 0) drive(1, 5, 17, 1'b1);
      else rnd(0, 1'b1);
      chk($sformatf("lat_valid_c%0d", k), obs_valid, (k == 7));
      if (k == 7) begin
        chk("lat_disp", obs_disp, 17);
        chk("lat_cost", obs_cost, 5);
        chk("lat_conf", obs_conf, 1);
      end
    end

    // Threshold table
    foreach (vecs[j]) begin
      bit got;
      got    = 1'b0;
      thresh = WIDTH'(vecs[j].th);
      drive(1, vecs[j].val, vecs[j].addr, 1'b1);
      for (int c = 0; c < 20 && !got; c++) begin
        rnd(0, 1'b1);
        if (obs_pop) begin
          got = 1'b1;
          chk($sformatf("tbl%0d_conf", j), obs_conf, vecs[j].conf);
          chk($sformatf("tbl%0d_disp", j), obs_disp, vecs[j].addr);
          chk($sformatf("tbl%0d_cost", j), obs_cost, vecs[j].val);
        end
      end
      chk($sformatf("tbl%0d_timeout", j), got, 1);
    end
    drain(30);

    // Back-pressure
    thresh = 30;
    reset_all();
    for (int i = 0; i < 20; i++) rnd(1, 1'b0);
    chk("bp_level_full", level, DEPTH);
    chk("bp_tree_en_low", tree_en, 0);
    rnd(1, 1'b0);
    chk("bp_level_hold", level, DEPTH);
    rnd(1, 1'b1);
    chk("bp_one_pop", obs_pop, 1);
    chk("bp_level_after_pushpop", level, DEPTH);
    rnd(1, 1'b0);
    chk("bp_level_still_full", level, DEPTH);
    drain(60);

    // Bubbles 1,0,1,1,0
    pop_cnt = 0;
    rnd(1, 1'b1);
    rnd(0, 1'b1);
    rnd(1, 1'b1);
    rnd(1, 1'b1);
    rnd(0, 1'b1);
    drain(40);
    chk("bubble_count", pop_cnt, 3);

    // Line tagging over 641 results
    reset_all();
    pop_cnt = 0;
    last_hits.delete();
    for (int i = 0; i < 641; i++) rnd(1, 1'b1);
    drain(40);
    chk("line_pops", pop_cnt, 641);
    chk("line_last_count", last_hits.size(), 2);
    if (last_hits.size() == 2) begin
      chk("line_last_first", last_hits[0], 320);
      chk("line_last_second", last_hits[1], 640);
    end

    // Mid-stream reset with level 5 and 3 in flight
    reset_all();
    for (int i = 0; i < 8; i++) rnd(1, 1'b0);
    for (int i = 0; i < 3; i++) rnd(0, 1'b0);
    chk("mid_level_before", level, 5);
    rst = 1'b0;
    #1;
    chk("mid_out_valid", out_valid, 0);
    chk("mid_level", level, 0);
    chk("mid_tree_en", tree_en, 1);
    chk("mid_outputs", {out_disp, out_cost, out_conf, out_last}, 0);
    flush();
    @(posedge clk);
    #1;
    rst = 1'b1;
    pop_cnt = 0;
    last_hits.delete();
    for (int i = 0; i < 700; i++) rnd(1, ($urandom_range(0, 3) != 0));
    drain(60);
    chk("mid_first_last_present", (last_hits.size() > 0), 1);
    if (last_hits.size() > 0)
      chk("mid_first_last_idx", last_hits[0], 320);

    // Random traffic
    thresh = WIDTH'($urandom_range(0, 63));
    for (int i = 0; i < 3000; i++)
      rnd(($urandom_range(0, 2) != 0), ($urandom_range(0, 3) != 0));
    drain(80);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
